// File: rtl/rv_decode_exec_stage_if.sv
// Bus bundle between the IF/ID register, the regfile read ports and the writeback
// stage on one side, and the decode/execute slice on the other.
interface rv_decode_exec_stage_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
);
    logic [XLEN-1:0]   pc_i;
    logic [XLEN-1:0]   inst_i;
    logic [XLEN-1:0]   reg1_data_i;
    logic [XLEN-1:0]   reg2_data_i;
    logic              reg1_read_o;
    logic              reg2_read_o;
    logic [REG_AW-1:0] reg1_addr_o;
    logic [REG_AW-1:0] reg2_addr_o;
    logic              wb_we_o;
    logic [REG_AW-1:0] wb_waddr_o;
    logic [XLEN-1:0]   wb_wdata_o;

    // The stage itself: consumes IF/ID and read data, drives read requests and writeback.
    modport master (
        input  pc_i,
        input  inst_i,
        input  reg1_data_i,
        input  reg2_data_i,
        output reg1_read_o,
        output reg2_read_o,
        output reg1_addr_o,
        output reg2_addr_o,
        output wb_we_o,
        output wb_waddr_o,
        output wb_wdata_o
    );

    // Surrounding pipeline: IF/ID register, regfile and writeback.
    modport slave (
        output pc_i,
        output inst_i,
        output reg1_data_i,
        output reg2_data_i,
        input  reg1_read_o,
        input  reg2_read_o,
        input  reg1_addr_o,
        input  reg2_addr_o,
        input  wb_we_o,
        input  wb_waddr_o,
        input  wb_wdata_o
    );
endinterface

// File: rtl/rv_decode_exec_stage.sv
// RV32I integer decode + execute + EX/WB slice: decodes the IF/ID instruction,
// registers operands into ID/EX, computes the ALU result and registers it into EX/WB.
module rv_decode_exec_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    rv_decode_exec_stage_if.master bus
);

    typedef enum logic [6:0] {
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111
    } opcode_e;

    typedef enum logic [2:0] {
        CLS_NOP   = 3'd0,
        CLS_OPIMM = 3'd1,
        CLS_OP    = 3'd2,
        CLS_LUI   = 3'd3,
        CLS_AUIPC = 3'd4
    } op_class_e;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } funct3_e;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]        opcode;
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;
    logic              bit30;
    logic [XLEN-1:0]   imm_i;
    logic [XLEN-1:0]   imm_u;
    logic [XLEN-1:0]   rdata1;
    logic [XLEN-1:0]   rdata2;

    assign opcode = bus.inst_i[6:0];
    assign rd     = bus.inst_i[11:7];
    assign funct3 = bus.inst_i[14:12];
    assign bit30  = bus.inst_i[30];
    assign imm_i  = {{(XLEN-12){bus.inst_i[31]}}, bus.inst_i[31:20]};
    assign imm_u  = {bus.inst_i[31:12], 12'b0};

    assign bus.reg1_addr_o = bus.inst_i[19:15];
    assign bus.reg2_addr_o = bus.inst_i[24:20];

    op_class_e         dec_cls;
    logic              dec_read1;
    logic              dec_read2;
    logic [XLEN-1:0]   dec_op1;
    logic [XLEN-1:0]   dec_op2;
    logic              dec_we;
    logic [REG_AW-1:0] dec_waddr;
    logic [2:0]        dec_funct3;
    logic              dec_bit30;

    always_comb begin
        dec_cls    = CLS_NOP;
        dec_read1  = 1'b0;
        dec_read2  = 1'b0;
        dec_op1    = '0;
        dec_op2    = '0;
        dec_we     = 1'b0;
        dec_waddr  = '0;
        dec_funct3 = '0;
        dec_bit30  = 1'b0;

        unique case (opcode)
            OPC_OP_IMM: begin
                dec_cls    = CLS_OPIMM;
                dec_read1  = 1'b1;
                dec_op1    = rdata1;
                dec_op2    = imm_i;
                dec_we     = 1'b1;
                dec_waddr  = rd;
                dec_funct3 = funct3;
                dec_bit30  = bit30;
            end
            OPC_OP: begin
                dec_cls    = CLS_OP;
                dec_read1  = 1'b1;
                dec_read2  = 1'b1;
                dec_op1    = rdata1;
                dec_op2    = rdata2;
                dec_we     = 1'b1;
                dec_waddr  = rd;
                dec_funct3 = funct3;
                dec_bit30  = bit30;
            end
            OPC_LUI: begin
                dec_cls   = CLS_LUI;
                dec_op2   = imm_u;
                dec_we    = 1'b1;
                dec_waddr = rd;
            end
            OPC_AUIPC: begin
                dec_cls   = CLS_AUIPC;
                dec_op1   = bus.pc_i;
                dec_op2   = imm_u;
                dec_we    = 1'b1;
                dec_waddr = rd;
            end
            default: ;
        endcase

        // x0 is never written; waddr is zero in that case anyway.
        if (rd == '0) begin
            dec_we = 1'b0;
        end
    end

    assign bus.reg1_read_o = dec_read1;
    assign bus.reg2_read_o = dec_read2;

    // Read data is gated by the enables so a disabled port never leaks into the operands.
    assign rdata1 = dec_read1 ? bus.reg1_data_i : '0;
    assign rdata2 = dec_read2 ? bus.reg2_data_i : '0;

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    op_class_e         ex_cls;
    logic [2:0]        ex_funct3;
    logic              ex_bit30;
    logic [XLEN-1:0]   ex_op1;
    logic [XLEN-1:0]   ex_op2;
    logic              ex_we;
    logic [REG_AW-1:0] ex_waddr;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_cls    <= CLS_NOP;
            ex_funct3 <= '0;
            ex_bit30  <= 1'b0;
            ex_op1    <= '0;
            ex_op2    <= '0;
            ex_we     <= 1'b0;
            ex_waddr  <= '0;
        end else begin
            ex_cls    <= dec_cls;
            ex_funct3 <= dec_funct3;
            ex_bit30  <= dec_bit30;
            ex_op1    <= dec_op1;
            ex_op2    <= dec_op2;
            ex_we     <= dec_we;
            ex_waddr  <= dec_waddr;
        end
    end

    // ------------------------------------------------------------------
    // Execute
    // ------------------------------------------------------------------
    logic [4:0]      shamt;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic            lt_signed;
    logic            lt_unsigned;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] ex_result;

    assign shamt       = ex_op2[4:0];
    assign sum         = ex_op1 + ex_op2;
    assign diff        = ex_op1 - ex_op2;
    assign lt_signed   = $signed(ex_op1) < $signed(ex_op2);
    assign lt_unsigned = ex_op1 < ex_op2;

    always_comb begin
        alu_res = '0;
        unique case (funct3_e'(ex_funct3))
            // bit30 is immediate payload for ADDI, so it only selects SUB for register ops.
            F3_ADD:  alu_res = (ex_cls == CLS_OP && ex_bit30) ? diff : sum;
            F3_SLL:  alu_res = ex_op1 << shamt;
            F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_signed};
            F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_unsigned};
            F3_XOR:  alu_res = ex_op1 ^ ex_op2;
            F3_SR:   alu_res = ex_bit30 ? $unsigned($signed(ex_op1) >>> shamt)
                                        : (ex_op1 >> shamt);
            F3_OR:   alu_res = ex_op1 | ex_op2;
            F3_AND:  alu_res = ex_op1 & ex_op2;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        ex_result = '0;
        unique case (ex_cls)
            CLS_OPIMM, CLS_OP: ex_result = alu_res;
            CLS_LUI:           ex_result = ex_op2;
            CLS_AUIPC:         ex_result = sum;
            default:           ex_result = '0;
        endcase
        if (!ex_we) begin
            ex_result = '0;
        end
    end

    // ------------------------------------------------------------------
    // EX/WB register
    // ------------------------------------------------------------------
    logic              wb_we;
    logic [REG_AW-1:0] wb_waddr;
    logic [XLEN-1:0]   wb_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_we    <= 1'b0;
            wb_waddr <= '0;
            wb_wdata <= '0;
        end else begin
            wb_we    <= ex_we;
            wb_waddr <= ex_waddr;
            wb_wdata <= ex_result;
        end
    end

    assign bus.wb_we_o    = wb_we;
    assign bus.wb_waddr_o = wb_waddr;
    assign bus.wb_wdata_o = wb_wdata;

endmodule

// File: tb/tb_rv_decode_exec_stage.sv
// Scoreboard bench for rv_decode_exec_stage: stimulus queues expected decode and
// writeback responses, a negedge monitor pops and compares them when they fall due.
module tb_rv_decode_exec_stage;

    typedef struct {
        int          due;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } wb_exp_t;

    typedef struct {
        int         due;
        logic       r1;
        logic       r2;
        logic [4:0] a1;
        logic [4:0] a2;
    } dec_exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;
    bit   done;

    wb_exp_t  wb_q[$];
    string    wb_name_q[$];
    dec_exp_t dec_q[$];
    string    dec_name_q[$];

    rv_decode_exec_stage_if bus ();

    rv_decode_exec_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic expect_wb(input int due, input logic we, input logic [4:0] waddr,
                             input logic [31:0] wdata, input string name);
        wb_exp_t e;
        e.due = due; e.we = we; e.waddr = waddr; e.wdata = wdata;
        wb_q.push_back(e);
        wb_name_q.push_back(name);
    endtask

    // Called just after a rising edge; drives one instruction for the current cycle.
    task automatic issue(input string name, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic r1, input logic r2,
                         input logic we, input logic [4:0] waddr, input logic [31:0] wdata);
        dec_exp_t d;
        bus.inst_i      = inst;
        bus.pc_i        = pc;
        bus.reg1_data_i = d1;
        bus.reg2_data_i = d2;
        d.due = cyc; d.r1 = r1; d.r2 = r2; d.a1 = inst[19:15]; d.a2 = inst[24:20];
        dec_q.push_back(d);
        dec_name_q.push_back(name);
        expect_wb(cyc + 2, we, waddr, wdata, name);
        @(posedge clk);
        #1;
    endtask

    // Monitor
    initial begin
        wb_exp_t  e;
        dec_exp_t d;
        string    n;
        checks   = 0;
        failures = 0;
        while (!done) begin
            @(negedge clk);
            while (dec_q.size() > 0 && dec_q[0].due < cyc) begin
                d = dec_q.pop_front(); n = dec_name_q.pop_front();
                checks++; failures++;
                $display("FAIL dec[%s] missed: due cycle %0d, now %0d", n, d.due, cyc);
            end
            if (dec_q.size() > 0 && dec_q[0].due == cyc) begin
                d = dec_q.pop_front(); n = dec_name_q.pop_front();
                checks++;
                if (bus.reg1_read_o !== d.r1 || bus.reg2_read_o !== d.r2 ||
                    bus.reg1_addr_o !== d.a1 || bus.reg2_addr_o !== d.a2) begin
                    failures++;
                    $display("FAIL dec[%s] actual r1=%0b r2=%0b a1=%0d a2=%0d required r1=%0b r2=%0b a1=%0d a2=%0d",
                             n, bus.reg1_read_o, bus.reg2_read_o, bus.reg1_addr_o, bus.reg2_addr_o,
                             d.r1, d.r2, d.a1, d.a2);
                end
            end
            while (wb_q.size() > 0 && wb_q[0].due < cyc) begin
                e = wb_q.pop_front(); n = wb_name_q.pop_front();
                checks++; failures++;
                $display("FAIL wb[%s] missed: due cycle %0d, now %0d", n, e.due, cyc);
            end
            if (wb_q.size() > 0 && wb_q[0].due == cyc) begin
                e = wb_q.pop_front(); n = wb_name_q.pop_front();
                checks++;
                if (bus.wb_we_o !== e.we || bus.wb_waddr_o !== e.waddr || bus.wb_wdata_o !== e.wdata) begin
                    failures++;
                    $display("FAIL wb[%s] cycle %0d actual we=%0b waddr=%0d wdata=%08h required we=%0b waddr=%0d wdata=%08h",
                             n, cyc, bus.wb_we_o, bus.wb_waddr_o, bus.wb_wdata_o, e.we, e.waddr, e.wdata);
                end
            end
        end
    end

    // Stimulus
    initial begin
        done            = 1'b0;
        rst             = 1'b1;
        bus.inst_i      = 32'h0010_0093;   // ADDI x1, x0, 1
        bus.pc_i        = '0;
        bus.reg1_data_i = '0;
        bus.reg2_data_i = '0;
        expect_wb(1, 1'b0, 5'd0, 32'h0, "reset_c1");
        expect_wb(2, 1'b0, 5'd0, 32'h0, "reset_c2");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_wb(cyc + 1, 1'b0, 5'd0, 32'h0, "post_reset");

        issue("ori",   32'h1230_6093, 32'h0, 32'h0,        32'h0,        1, 0, 1, 5'd1,  32'h0000_0123);
        issue("sub",   32'h4020_81B3, 32'h0, 32'd5,        32'd7,        1, 1, 1, 5'd3,  32'hFFFF_FFFE);
        issue("slt",   32'h0020_A233, 32'h0, 32'hFFFF_FFFF, 32'd1,       1, 1, 1, 5'd4,  32'h0000_0001);
        issue("sltu",  32'h0020_B233, 32'h0, 32'hFFFF_FFFF, 32'd1,       1, 1, 1, 5'd4,  32'h0000_0000);
        issue("srai",  32'h4042_5293, 32'h0, 32'h8000_0000, 32'h0,       1, 0, 1, 5'd5,  32'hF800_0000);
        issue("lui",   32'hABCD_E337, 32'h0, 32'h1111_1111, 32'h2222_2222, 0, 0, 1, 5'd6, 32'hABCD_E000);
        issue("auipc", 32'h1234_5517, 32'h100, 32'h0,      32'h0,        0, 0, 1, 5'd10, 32'h1234_5100);
        issue("addi_gate", 32'hFF00_8593, 32'h0, 32'h20,   32'hDEAD,     1, 0, 1, 5'd11, 32'h0000_0010);
        issue("sra",   32'h4020_D633, 32'h0, 32'hF000_0000, 32'h24,      1, 1, 1, 5'd12, 32'hFF00_0000);
        issue("srli",  32'h0080_D693, 32'h0, 32'hF000_0000, 32'h0,       1, 0, 1, 5'd13, 32'h00F0_0000);
        issue("xor",   32'h0020_C733, 32'h0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1, 1, 1, 5'd14, 32'hF0F0_F0F0);
        issue("add_wrap", 32'h0020_87B3, 32'h0, 32'hFFFF_FFFF, 32'd2,    1, 1, 1, 5'd15, 32'h0000_0001);

        // Back-to-back: x7 = -1, then a write to x0, then an illegal opcode.
        issue("addi_x7", 32'hFFF0_0393, 32'h0, 32'h0, 32'h0,            1, 0, 1, 5'd7,  32'hFFFF_FFFF);
        issue("addi_x0", 32'h0050_0013, 32'h0, 32'h0, 32'h0,            1, 0, 0, 5'd0,  32'h0);
        issue("illegal", 32'h0000_0000, 32'h0, 32'h1234, 32'h5678,      0, 0, 0, 5'd0,  32'h0);

        // Mid-stream reset: x8 completes, x9 is discarded.
        issue("addi_x8", 32'h0080_0413, 32'h0, 32'h0, 32'h0,            1, 0, 1, 5'd8,  32'h0000_0008);
        issue("x9_flushed", 32'h0090_0493, 32'h0, 32'h0, 32'h0,         1, 0, 0, 5'd0,  32'h0);
        rst        = 1'b1;
        bus.inst_i = 32'h0000_0000;
        expect_wb(cyc + 2, 1'b0, 5'd0, 32'h0, "after_midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue("ori_after", 32'h1230_6093, 32'h0, 32'h0, 32'h0,          1, 0, 1, 5'd1,  32'h0000_0123);
        issue("idle",      32'h0000_0000, 32'h0, 32'h0, 32'h0,          0, 0, 0, 5'd0,  32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        done = 1'b1;

        checks++;
        if (wb_q.size() != 0 || dec_q.size() != 0) begin
            failures++;
            $display("FAIL drain: actual pending wb=%0d dec=%0d required 0", wb_q.size(), dec_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: actual cycle %0d required completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
